// File: rtl/v14_pulse_generator.sv
// v14_pulse_generator
//
// Synthetic detector-pulse source standing in for the ADC feed of the v14
// trapezoidal shaping chain. Each accepted trigger produces one pulse on top
// of a programmable pedestal: a linear rise over 2^RISE_SHIFT samples that
// lands exactly on the requested amplitude, followed by a shift-based
// exponential decay (tau ~ 2^DECAY_SHIFT samples) back to the pedestal.
//
// Parameters:
//   DATA_W       sample width (signed two's complement output)
//   RISE_SHIFT   rise length is 2^RISE_SHIFT samples (must be >= 1)
//   DECAY_SHIFT  per-sample decay is acc >> DECAY_SHIFT
//
// Ports:
//   clk          sample clock, rising edge; output settles on posedge so the
//                filter can sample it on negedge
//   reset        asynchronous, active-high
//   start        trigger request, accepted only while ready
//   amplitude    unsigned pulse height (DATA_W-1 bits), latched at accept
//   baseline     signed pedestal, tracked while idle, frozen during a pulse
//   ready        high while idle
//   pulse_done   one-cycle strobe at the end of a pulse (or of a skipped one)
//   dropped_cnt  saturating count of start requests seen while busy
//   output_data  registered, clamped sample baseline + pulse
module v14_pulse_generator #(
  parameter int DATA_W      = 12,
  parameter int RISE_SHIFT  = 2,
  parameter int DECAY_SHIFT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-2:0] amplitude,
  input  logic [DATA_W-1:0] baseline,
  output logic              ready,
  output logic              pulse_done,
  output logic [7:0]        dropped_cnt,
  output logic [DATA_W-1:0] output_data
);

  localparam int AW = DATA_W - 1;
  localparam logic [RISE_SHIFT-1:0] RISE_LAST = {RISE_SHIFT{1'b1}};
  localparam logic [DATA_W-1:0]     OUT_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]     OUT_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

  state_t                state, state_next;
  logic [AW-1:0]         acc, acc_next;
  logic [AW-1:0]         step, step_next;
  logic [AW-1:0]         amp_l, amp_next;
  logic [RISE_SHIFT-1:0] rise_cnt, rise_cnt_next;
  logic [DATA_W-1:0]     base_l, base_next;
  logic                  done_next;
  logic [7:0]            drop_next;
  logic [DATA_W:0]       sum;
  logic [DATA_W-1:0]     out_next;
  logic                  amp_small;
  logic                  acc_small;

  // "value < 2^DECAY_SHIFT" expressed as "no bits left above the shift".
  assign amp_small = ((amplitude >> DECAY_SHIFT) == '0);
  assign acc_small = ((acc >> DECAY_SHIFT) == '0);

  assign ready = (state == IDLE);

  always_comb begin
    state_next    = state;
    acc_next      = acc;
    step_next     = step;
    amp_next      = amp_l;
    rise_cnt_next = rise_cnt;
    base_next     = base_l;
    done_next     = 1'b0;
    drop_next     = dropped_cnt;
    sum           = '0;
    out_next      = '0;

    case (state)
      IDLE: begin
        acc_next  = '0;
        base_next = baseline;
        if (start) begin
          amp_next  = amplitude;
          step_next = amplitude >> RISE_SHIFT;
          if (amp_small) begin
            // Too small to decay meaningfully: report completion immediately.
            done_next = 1'b1;
          end else begin
            acc_next      = amplitude >> RISE_SHIFT;
            rise_cnt_next = RISE_SHIFT'(1);
            state_next    = RISE;
          end
        end
      end
      RISE: begin
        if (rise_cnt == RISE_LAST) begin
          // Snap to the exact amplitude so step truncation never shows at the peak.
          acc_next   = amp_l;
          state_next = DECAY;
        end else begin
          acc_next      = acc + step;
          rise_cnt_next = rise_cnt + RISE_SHIFT'(1);
        end
      end
      DECAY: begin
        if (acc_small) begin
          // The shift term has reached zero; finish instead of stalling.
          acc_next   = '0;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          acc_next = acc - (acc >> DECAY_SHIFT);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if ((state != IDLE) && start && (dropped_cnt != 8'hFF)) begin
      drop_next = dropped_cnt + 8'd1;
    end

    // One extra bit of headroom, then saturate instead of wrapping.
    sum = {base_l[DATA_W-1], base_l} + {2'b00, acc};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      out_next = sum[DATA_W] ? OUT_MIN : OUT_MAX;
    end else begin
      out_next = sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      step        <= '0;
      amp_l       <= '0;
      rise_cnt    <= '0;
      base_l      <= '0;
      pulse_done  <= 1'b0;
      dropped_cnt <= 8'd0;
      output_data <= '0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      step        <= step_next;
      amp_l       <= amp_next;
      rise_cnt    <= rise_cnt_next;
      base_l      <= base_next;
      pulse_done  <= done_next;
      dropped_cnt <= drop_next;
      output_data <= out_next;
    end
  end

endmodule
